// File: rtl/pipeline_skid_register_if.sv
// Valid/ready bundle between two pipeline stages.
// The register is the slave side; the driving and consuming stages are the master side.
interface pipeline_skid_register_if #(
  parameter int NUM_BITS = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [NUM_BITS-1:0] din;
  logic                out_valid;
  logic                out_ready;
  logic [NUM_BITS-1:0] dout;

  modport master (
    output in_valid,
    output din,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  dout
  );

  modport slave (
    input  in_valid,
    input  din,
    input  out_ready,
    output in_ready,
    output out_valid,
    output dout
  );
endinterface

// File: rtl/pipeline_skid_register.sv
// Falling-edge pipeline register with 2-entry skid buffer,
// synchronous flush and saturating stall counter.
module pipeline_skid_register #(
  parameter int                NUM_BITS     = 16,
  parameter logic [NUM_BITS-1:0] BUBBLE_VALUE = '0,
  parameter int                CNT_BITS     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  pipeline_skid_register_if.slave bus,
  output logic [CNT_BITS-1:0] stall_count
);

  // State bits are {out_valid, ~in_ready} so both flags come straight from flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

  state_t              state, state_n;
  logic [NUM_BITS-1:0] main_q, main_n;
  logic [NUM_BITS-1:0] skid_q, skid_n;
  logic [CNT_BITS-1:0] cnt_q, cnt_n;
  logic                in_xfer, out_xfer;

  assign bus.out_valid = state[1];
  assign bus.in_ready  = ~state[0];
  assign bus.dout      = main_q;
  assign stall_count   = cnt_q;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    cnt_n   = cnt_q;
    if (flush) begin
      state_n = EMPTY;
      main_n  = BUBBLE_VALUE;
      skid_n  = BUBBLE_VALUE;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_n = ONE;
            main_n  = bus.din;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_n = bus.din;
          end else if (in_xfer) begin
            state_n = FULL;
            skid_n  = bus.din;
          end else if (out_xfer) begin
            state_n = EMPTY;
            main_n  = BUBBLE_VALUE;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_n = ONE;
            main_n  = skid_q;
            skid_n  = BUBBLE_VALUE;
          end
        end
        default: begin
          state_n = EMPTY;
          main_n  = BUBBLE_VALUE;
          skid_n  = BUBBLE_VALUE;
        end
      endcase
      if (bus.out_valid && !bus.out_ready && cnt_q != CNT_MAX)
        cnt_n = cnt_q + 1'b1;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= BUBBLE_VALUE;
      skid_q <= BUBBLE_VALUE;
      cnt_q  <= '0;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
      cnt_q  <= cnt_n;
    end
  end

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Directed bench for pipeline_skid_register (NUM_BITS=16, CNT_BITS=4).
// Inputs change just after a falling edge; outputs sampled 1 time unit later.
module tb_pipeline_skid_register;

  localparam int NB = 16;
  localparam int CB = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [CB-1:0] stall_count;
  int            checks;
  int            errors;

  pipeline_skid_register_if #(.NUM_BITS(NB)) bus ();

  pipeline_skid_register #(
    .NUM_BITS(NB),
    .BUBBLE_VALUE(16'h0000),
    .CNT_BITS(CB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(bus.slave),
    .stall_count(stall_count)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic r,
                         input logic [NB-1:0] d, input logic [CB-1:0] s);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(r));
    chk({tag, ".dout"}, 32'(bus.dout), 32'(d));
    chk({tag, ".stall"}, 32'(stall_count), 32'(s));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.out_ready = 1'b0;
    #12;
    chk_out("reset", 1'b0, 1'b1, 16'h0000, 4'd0);
    rst_n = 1'b1;

    // streaming at full throughput
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.din = 16'h0001;
    tick(); chk_out("stream1", 1'b1, 1'b1, 16'h0001, 4'd0);
    bus.din = 16'h0002;
    tick(); chk_out("stream2", 1'b1, 1'b1, 16'h0002, 4'd0);
    bus.din = 16'h0003;
    tick(); chk_out("stream3", 1'b1, 1'b1, 16'h0003, 4'd0);
    bus.in_valid = 1'b0; bus.din = 16'hxxxx;
    tick(); chk_out("drain", 1'b0, 1'b1, 16'h0000, 4'd0);

    // backpressure into the skid entry
    bus.in_valid = 1'b1; bus.out_ready = 1'b0; bus.din = 16'h00A1;
    tick(); chk_out("skid_one", 1'b1, 1'b1, 16'h00A1, 4'd0);
    bus.din = 16'h00A2;
    tick(); chk_out("skid_full", 1'b1, 1'b0, 16'h00A1, 4'd1);
    bus.din = 16'h00FF;
    tick(); tick(); tick();
    chk_out("skid_stall", 1'b1, 1'b0, 16'h00A1, 4'd4);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick(); chk_out("skid_pop1", 1'b1, 1'b1, 16'h00A2, 4'd4);
    tick(); chk_out("skid_pop2", 1'b0, 1'b1, 16'h0000, 4'd4);

    // flush beats both transfers
    bus.in_valid = 1'b1; bus.out_ready = 1'b0; bus.din = 16'h0011;
    tick(); chk_out("fl_one", 1'b1, 1'b1, 16'h0011, 4'd4);
    bus.din = 16'h0022;
    tick(); chk_out("fl_full", 1'b1, 1'b0, 16'h0011, 4'd5);
    flush = 1'b1; bus.out_ready = 1'b1; bus.din = 16'h0033;
    tick(); chk_out("fl_edge", 1'b0, 1'b1, 16'h0000, 4'd5);
    flush = 1'b0; bus.in_valid = 1'b0;
    tick(); chk_out("fl_after", 1'b0, 1'b1, 16'h0000, 4'd5);
    flush = 1'b1; bus.in_valid = 1'b1; bus.din = 16'h0044;
    tick(); tick(); chk_out("fl_hold", 1'b0, 1'b1, 16'h0000, 4'd5);

    // stall counter saturation
    flush = 1'b0; bus.out_ready = 1'b0; bus.din = 16'h0066;
    tick(); chk_out("sat_load", 1'b1, 1'b1, 16'h0066, 4'd5);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9) chk("sat_reach", 32'(stall_count), 32'd15);
    end
    chk_out("sat_hold", 1'b1, 1'b1, 16'h0066, 4'd15);
    flush = 1'b1;
    tick(); chk_out("sat_flush", 1'b0, 1'b1, 16'h0000, 4'd15);
    flush = 1'b0;

    // asynchronous reset between edges
    bus.in_valid = 1'b1; bus.din = 16'h0077;
    tick(); bus.din = 16'h0078;
    tick(); chk_out("ar_full", 1'b1, 1'b0, 16'h0077, 4'd15);
    #2 rst_n = 1'b0;
    #1 chk_out("ar_async", 1'b0, 1'b1, 16'h0000, 4'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.din = 16'h0055;
    tick(); chk_out("ar_first", 1'b1, 1'b1, 16'h0055, 4'd0);
    bus.in_valid = 1'b0;
    tick(); chk_out("ar_drain", 1'b0, 1'b1, 16'h0000, 4'd0);

    // capture only on falling edges
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.din = 16'h0099; bus.out_ready = 1'b0;
    #3 chk_out("fe_pre", 1'b0, 1'b1, 16'h0000, 4'd0);
    tick(); chk_out("fe_cap", 1'b1, 1'b1, 16'h0099, 4'd0);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk_out("fe_rise", 1'b1, 1'b1, 16'h0099, 4'd0);
    tick(); chk_out("fe_pop", 1'b0, 1'b1, 16'h0000, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_skid_register.md
Name: pipeline_skid_register

Overview:
- Next-generation parametrised pipeline register for the processor datapath between stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, a 2-entry skid buffer for full-throughput stalls, a synchronous flush that inserts a bubble, and a saturating stall-cycle counter.
- Captures on the falling edge of clk, so stage logic keeps the whole rising-to-falling window.

Parameters:
- NUM_BITS, 16, width of the stage payload din/dout.
- BUBBLE_VALUE, 0 (NUM_BITS wide), payload driven on dout whenever out_valid=0; encodes a NOP.
- CNT_BITS, 8, width of stall_count.

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash; sampled at the falling edge.
- in_valid  input  1  upstream stage presents a beat on din.
- in_ready  output  1  register can accept a beat.
- din  input  NUM_BITS  upstream payload.
- out_valid  output  1  dout holds a valid beat.
- out_ready  input  1  downstream stage consumes the beat.
- dout  output  NUM_BITS  payload to the downstream stage.
- stall_count  output  CNT_BITS  number of falling edges with out_valid=1 and out_ready=0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=EMPTY, out_valid=0, in_ready=1, dout=BUBBLE_VALUE, skid contents=BUBBLE_VALUE, stall_count=0.
  - Release is taken at the next falling edge.
- Storage:
  - main register drives dout.
  - skid register holds a second beat.
  - All outputs come from flops. No combinational path from out_ready to in_ready.
- Transfer definitions:
  - in_xfer = in_valid & in_ready at a falling edge.
  - out_xfer = out_valid & out_ready at a falling edge.
- States (encoded as occupancy):
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Transitions (no flush):
  - EMPTY: in_xfer -> ONE, main<=din. Otherwise hold.
  - ONE: in_xfer & out_xfer -> ONE, main<=din.
  - ONE: in_xfer only -> FULL, skid<=din, main unchanged.
  - ONE: out_xfer only -> EMPTY.
  - ONE: neither -> hold.
  - FULL: out_xfer -> ONE, main<=skid, skid<=BUBBLE_VALUE. Otherwise hold. in_xfer is impossible in FULL.
- Ordering and timing:
  - Beats leave in strict arrival order.
  - Latency: a beat accepted at edge N is on dout/out_valid immediately after edge N when the register was EMPTY.
  - Throughput: 1 beat per cycle while out_ready=1.
- dout is forced to BUBBLE_VALUE whenever out_valid=0. No stale payload is ever visible.
- Flush:
  - flush=1 at a falling edge: state<=EMPTY, main and skid <= BUBBLE_VALUE, out_valid<=0, in_ready<=1.
  - Overrides in_xfer and out_xfer at the same edge. The beat offered on din is discarded, and upstream treats it as squashed.
  - A beat on dout at that edge is also squashed, even if out_ready=1.
  - Flush held over multiple edges keeps the register EMPTY.
- stall_count:
  - Increments at each falling edge where out_valid=1 & out_ready=0 & flush=0.
  - Saturates at 2^CNT_BITS-1. No wrap.
  - Cleared only by rst_n, not by flush.
- Input rules:
  - in_valid high while in_ready=0: no effect. Upstream holds din stable until accepted.
  - X/any value on din is ignored when in_valid=0.
- Reset mid-operation: both stored beats are lost immediately. Outputs go to reset values without waiting for a clock edge.

Test Plan:
- Reset then stream: rst_n low, release, NUM_BITS=16, out_ready=1, in_valid=1, din=0x0001,0x0002,0x0003 on consecutive cycles -> out_valid=1 from first falling edge; dout follows 0x0001,0x0002,0x0003 one per cycle; in_ready stays 1; stall_count=0.
- Backpressure/skid: in ONE holding 0x00A1, out_ready=0, push 0x00A2 -> FULL, in_ready=0, dout=0x00A1. 3 further stalled edges -> stall_count=4. Raise out_ready -> dout 0x00A1 then 0x00A2, no loss or duplication, in_ready returns to 1.
- Flush priority: FULL with 0x0011/0x0022, assert flush with in_valid=1, din=0x0033, out_ready=1 for one edge -> out_valid=0, dout=BUBBLE_VALUE, in_ready=1. 0x0033 never appears. stall_count unchanged.
- Saturation: CNT_BITS=4, hold out_valid=1 with out_ready=0 for 20 edges -> stall_count reaches 15 and stays 15. Flush leaves it at 15. rst_n clears it to 0.
- Async reset mid-stream: FULL state, drop rst_n between clock edges -> out_valid=0, in_ready=1, dout=BUBBLE_VALUE before the next clk edge. After release, first pushed beat 0x0055 appears at the next falling edge.
- Falling-edge capture: change din/in_valid only around rising edges -> acceptance occurs exactly at falling edges. Rising edges never alter state.
